receive_control: RTL and testbench

//   Serial receive path of the SPART: oversamples rxd using the shared baud enable and

---
 rtl/spart_pkg.sv | 9 +
 rtl/rx_buffer.sv | 50 +++++
 rtl/receive_control.sv | 139 +++++++++++++
 tb/tb_receive_control.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and constants
package spart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_buffer.sv
// rtl/rx_buffer.sv - receive byte FIFO with combinational head output
module rx_buffer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/receive_control.sv
// rtl/receive_control.sv - SPART 8N1 receive deframer with byte buffer
module receive_control
  import spart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OSR   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_en,
  input  logic       rxd,
  input  logic       fifo_read,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun,
  output logic       frame_err
);

  localparam int OSW = $clog2(OSR);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OSR/2 - 1);
  localparam logic [OSW-1:0] OS_END   = OSW'(OSR - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_sync_q, rx;
  logic [OSW-1:0]       os_cnt_q, os_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_err_q, stop_err_d;
  logic                 overrun_q, frame_err_q;
  logic                 push_w, set_fe, set_ovr, buf_empty, buf_full;

  assign rx = rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (rx != IDLE_LEVEL) state_d = START;
      START: if (baud_en && os_cnt_q == OS_MID) state_d = (rx == IDLE_LEVEL) ? IDLE : DATA;
      DATA:  if (baud_en && os_cnt_q == OS_END && bit_cnt_q == BIT_LAST) state_d = STOP;
      STOP: begin
        // After a bad stop bit, hold here until the line is released.
        if (stop_err_q) begin
          if (rx == IDLE_LEVEL) state_d = IDLE;
        end else if (baud_en && os_cnt_q == OS_END && rx == IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_err_d = stop_err_q;
    push_w     = 1'b0;
    set_fe     = 1'b0;
    case (state_q)
      IDLE: begin
        os_cnt_d   = '0;
        bit_cnt_d  = '0;
        stop_err_d = 1'b0;
      end
      START: if (baud_en) os_cnt_d = (os_cnt_q == OS_MID) ? '0 : os_cnt_q + 1'b1;
      DATA: if (baud_en) begin
        if (os_cnt_q == OS_END) begin
          os_cnt_d  = '0;
          shift_d   = {rx, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      STOP: if (baud_en && !stop_err_q) begin
        if (os_cnt_q == OS_END) begin
          os_cnt_d = '0;
          if (rx == IDLE_LEVEL) begin
            push_w = 1'b1;
          end else begin
            set_fe     = 1'b1;
            stop_err_d = 1'b1;
          end
        end else begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      default: os_cnt_d = '0;
    endcase
  end

  assign set_ovr = push_w && buf_full && !fifo_read;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= IDLE_LEVEL;
      rx_sync_q   <= IDLE_LEVEL;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stop_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rx_sync_q   <= rx_meta_q;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      stop_err_q  <= stop_err_d;
      overrun_q   <= set_ovr ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
      frame_err_q <= set_fe  ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    end
  end

  rx_buffer #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_rx_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_w),
    .pop   (fifo_read),
    .din   (shift_q),
    .dout  (rx_data),
    .empty (buf_empty),
    .full  (buf_full)
  );

  assign rda       = !buf_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_receive_control.sv
// tb/tb_receive_control.sv - scoreboard bench for receive_control
module tb_receive_control;

  localparam int DEPTH    = 4;
  localparam int OSR      = 16;
  localparam int BIT_CLKS = 4 * OSR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       rxd = 1'b1;
  logic       fifo_read = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rda, overrun, frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  int         baud_phase = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  logic       exp_fe = 1'b0;
  bit         hit;

  receive_control #(.DEPTH(DEPTH), .OSR(OSR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_en   (baud_en),
    .rxd       (rxd),
    .fifo_read (fifo_read),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rda       (rda),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      baud_en = (baud_phase == 3);
      baud_phase = (baud_phase + 1) % 4;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: every read strobe the DUT sees is checked against the model queue.
  always @(negedge clk) begin
    if (rst_n && fifo_read) begin
      chk("read_rda", 8'(rda), 8'(exp_q.size() != 0));
      if (rda && exp_q.size() != 0) begin
        chk("read_data", rx_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_rda"}, 8'(rda), 8'(exp_q.size() != 0));
    chk({tag, "_rx_data"}, rx_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    chk({tag, "_overrun"}, 8'(overrun), 8'(exp_ovr));
    chk({tag, "_frame_err"}, 8'(frame_err), 8'(exp_fe));
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 rxd = b;
    repeat (BIT_CLKS - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    if (!stop) repeat (extra_low) send_bit(1'b0);
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (20) @(posedge clk);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovr = 1'b1;
    end else begin
      exp_fe = 1'b1;
    end
  endtask

  task automatic read_byte();
    @(posedge clk);
    #2 fifo_read = 1'b1;
    @(posedge clk);
    #2 fifo_read = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);

    send_frame(8'hA5, 1'b1, 0);
    check_state("a5");
    read_byte();
    check_state("a5_after_read");

    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (20) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (200) @(posedge clk);
    check_state("glitch");

    send_frame(8'h3C, 1'b0, 2);
    check_state("frame_err");
    send_frame(8'h55, 1'b1, 0);
    check_state("after_fe_55");
    read_byte();
    clear_err();
    check_state("fe_cleared");

    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 0);
    check_state("overrun");
    repeat (DEPTH) read_byte();
    read_byte();
    check_state("overrun_drained");
    clear_err();

    for (int k = 0; k < DEPTH; k++) send_frame(8'h11 + 8'(k), 1'b1, 0);
    check_state("full");
    hit = 1'b0;
    fork
      send_frame(8'h66, 1'b1, 0);
      begin
        for (int k = 0; k < 1500 && !hit; k++) begin
          @(posedge clk);
          #2;
          if (dut.push_w) hit = 1'b1;
        end
        if (hit) begin
          fifo_read = 1'b1;
          @(posedge clk);
          #2 fifo_read = 1'b0;
        end
      end
    join
    chk("coincident_push_seen", 8'(hit), 8'h01);
    check_state("coincident");
    repeat (DEPTH) read_byte();
    check_state("coincident_drained");

    for (int it = 0; it < 12; it++) begin
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0), int'($urandom_range(0, 2)));
      repeat ($urandom_range(5, 40)) @(posedge clk);
      check_state("random");
      repeat ($urandom_range(0, 2)) read_byte();
      if ($urandom_range(0, 3) == 0) clear_err();
    end
    repeat (DEPTH) read_byte();
    check_state("random_drained");

    send_frame(8'h42, 1'b1, 0);
    send_frame(8'h24, 1'b0, 0);
    check_state("pre_reset");
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_fe  = 1'b0;
    check_state("mid_frame_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    send_frame(8'h81, 1'b1, 0);
    check_state("post_reset_81");
    read_byte();
    check_state("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
